// File: rtl/bch_pkg.sv
// Shared BCH(63,24) constants and types.
// Used by the serial encoder and the receive-side checker.
package bch_pkg;

  localparam int          BCH_N  = 63;
  localparam int          BCH_K  = 24;
  localparam int          BCH_M  = BCH_N - BCH_K;
  localparam logic [39:0] BCH_G  = 40'hF69AC20921;
  localparam int          BCH_CW = $clog2(BCH_N);

  typedef enum logic {
    S_MSG = 1'b0,
    S_PAR = 1'b1
  } st_e;

endpackage

// File: rtl/bch_rem_lfsr.sv
// Bit-serial remainder divider by g(x), one bit per enabled cycle.
// clr restarts the division at this bit; done zeroes r after the step.
module bch_rem_lfsr
  import bch_pkg::*;
#(
  parameter int         M = BCH_M,
  parameter logic [M:0] G = BCH_G
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         b,
  input  logic         en,
  input  logic         clr,
  input  logic         done,
  output logic [M-1:0] r,
  output logic [M-1:0] r_nxt
);

  logic [M-1:0] r_q;
  logic [M-1:0] r_d;
  logic [M-1:0] seed;

  always_comb begin
    seed  = clr ? '0 : r_q;
    r_nxt = {seed[M-2:0], b} ^ (seed[M-1] ? G[M-1:0] : '0);
    r_d   = done ? '0 : r_nxt;
  end

  dfflr #(.W(M)) u_r (
    .clk  (clk),
    .rst_n(rst_n),
    .lden (en),
    .d    (r_d),
    .q    (r_q)
  );

  assign r = r_q;

endmodule

// File: rtl/dfflr.sv
// Load-enable register with asynchronous active-low reset to zero.
// Base state primitive for the codec blocks.
module dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lden,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (lden) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bch_check.sv
// Bit-serial BCH codeword checker: forwards message bits and
// reports the g(x) remainder and a pass/fail flag per frame.
module bch_check
  import bch_pkg::*;
#(
  parameter int             N     = BCH_N,
  parameter int             K     = BCH_K,
  parameter logic [N-K:0]   G     = BCH_G,
  parameter int             CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             sof,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic [N-K-1:0]   syn_out,
  output logic             busy,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int M  = N - K;
  localparam int CW = $clog2(N);

  logic           restart;
  logic           msg;
  logic           last;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [CW-1:0]  cnt_e;
  logic           st_bits;
  st_e            st_q;
  st_e            st_d;
  st_e            st_cur;
  logic [M-1:0]   r_q;
  logic [M-1:0]   r_nxt;

  logic           dout_q;
  logic           dout_d;
  logic           dov_q;
  logic           dov_d;
  logic           done_q;
  logic           done_d;
  logic           ferr_q;
  logic           ferr_d;
  logic [M-1:0]   syn_q;
  logic [M-1:0]   syn_d;
  logic           busy_q;
  logic           busy_d;
  logic [CNT_W-1:0] ecnt_q;
  logic [CNT_W-1:0] ecnt_d;
  logic           ecnt_en;

  assign st_q = st_e'(st_bits);

  // sof restarts the frame on this very bit
  always_comb begin
    restart = data_valid & sof;
    cnt_e   = restart ? '0 : cnt_q;
    st_cur  = restart ? S_MSG : st_q;
    msg     = data_valid & (st_cur == S_MSG);
    last    = data_valid & (cnt_e == CW'(N-1));
    cnt_d   = last ? '0 : cnt_e + 1'b1;
    st_d    = st_cur;
    unique case (1'b1)
      last:                  st_d = S_MSG;
      (cnt_e == CW'(K-1)):   st_d = S_PAR;
      default:               st_d = st_cur;
    endcase
    dout_d  = data_in;
    dov_d   = msg;
    done_d  = last;
    syn_d   = r_nxt;
    ferr_d  = |r_nxt;
    busy_d  = (cnt_d != '0);
    ecnt_d  = ecnt_q + 1'b1;
    ecnt_en = last & (|r_nxt) & ~(&ecnt_q);
  end

  bch_rem_lfsr #(.M(M), .G(G)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .b    (data_in),
    .en   (data_valid),
    .clr  (restart),
    .done (last),
    .r    (r_q),
    .r_nxt(r_nxt)
  );

  dfflr #(.W(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .lden(data_valid),
    .d(cnt_d), .q(cnt_q)
  );

  dfflr #(.W(1)) u_st (
    .clk(clk), .rst_n(rst_n), .lden(data_valid),
    .d(st_d), .q(st_bits)
  );

  dfflr #(.W(1)) u_busy (
    .clk(clk), .rst_n(rst_n), .lden(data_valid),
    .d(busy_d), .q(busy_q)
  );

  dfflr #(.W(1)) u_dout (
    .clk(clk), .rst_n(rst_n), .lden(msg),
    .d(dout_d), .q(dout_q)
  );

  dfflr #(.W(1)) u_dov (
    .clk(clk), .rst_n(rst_n), .lden(1'b1),
    .d(dov_d), .q(dov_q)
  );

  dfflr #(.W(1)) u_done (
    .clk(clk), .rst_n(rst_n), .lden(1'b1),
    .d(done_d), .q(done_q)
  );

  dfflr #(.W(1)) u_ferr (
    .clk(clk), .rst_n(rst_n), .lden(last),
    .d(ferr_d), .q(ferr_q)
  );

  dfflr #(.W(M)) u_syn (
    .clk(clk), .rst_n(rst_n), .lden(last),
    .d(syn_d), .q(syn_q)
  );

  dfflr #(.W(CNT_W)) u_ecnt (
    .clk(clk), .rst_n(rst_n), .lden(ecnt_en),
    .d(ecnt_d), .q(ecnt_q)
  );

  assign data_out       = dout_q;
  assign data_out_valid = dov_q;
  assign frame_done     = done_q;
  assign frame_err      = ferr_q;
  assign syn_out        = syn_q;
  assign busy           = busy_q;
  assign err_cnt        = ecnt_q;

endmodule

// File: tb/tb_bch_check.sv
// Directed bench for bch_check, with a behavioural encoder for loopback.
module tb_bch_check;

  localparam logic [39:0] GP = 40'hF69AC20921;

  logic        clk;
  logic        rst_n;
  logic        data_in;
  logic        data_valid;
  logic        sof;
  logic        data_out;
  logic        data_out_valid;
  logic        frame_done;
  logic        frame_err;
  logic [38:0] syn_out;
  logic        busy;
  logic [15:0] err_cnt;

  logic        d4_out;
  logic        d4_ov;
  logic        d4_done;
  logic        d4_err;
  logic [38:0] d4_syn;
  logic        d4_busy;
  logic [3:0]  err_cnt4;

  int nerr;
  int nchk;
  int ndone;
  logic outs[$];
  logic ferrs[$];

  bch_check dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .data_valid(data_valid), .sof(sof),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .frame_done(frame_done), .frame_err(frame_err),
    .syn_out(syn_out), .busy(busy), .err_cnt(err_cnt)
  );

  bch_check #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in),
    .data_valid(data_valid), .sof(sof),
    .data_out(d4_out), .data_out_valid(d4_ov),
    .frame_done(d4_done), .frame_err(d4_err),
    .syn_out(d4_syn), .busy(d4_busy), .err_cnt(err_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_out_valid) outs.push_back(data_out);
    if (frame_done) begin
      ndone++;
      ferrs.push_back(frame_err);
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [62:0] encode(logic [23:0] m);
    logic [38:0] p;
    logic        fb;
    p = '0;
    for (int i = 23; i >= 0; i--) begin
      fb = p[38] ^ m[i];
      p  = {p[37:0], 1'b0} ^ (fb ? GP[38:0] : 39'h0);
    end
    return {m, p};
  endfunction

  task automatic send_bit(input logic b, input logic s);
    data_in    = b;
    sof        = s;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    sof        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [62:0] cw, input int gapmax,
                            input logic first_sof);
    for (int i = 62; i >= 0; i--) begin
      if (gapmax > 0 && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, gapmax));
      send_bit(cw[i], first_sof && i == 62);
    end
  endtask

  function automatic logic [23:0] pack24(int base);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 24; i++) v = {v[22:0], outs[base+i]};
    return v;
  endfunction

  initial begin
    logic [62:0] cw;
    logic [23:0] msgs [6];
    int          ones;
    int          bad;
    int          d0;
    nerr = 0; nchk = 0; ndone = 0;
    rst_n = 1'b0; data_in = 1'b0; data_valid = 1'b0; sof = 1'b0;
    idle(3);
    chk("rst_dov", data_out_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_syn", syn_out, 0);
    chk("rst_misc", {data_out, frame_err, busy}, 0);
    chk("rst_ecnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // all-zero codeword
    outs.delete(); ferrs.delete(); d0 = ndone;
    send_frame(63'h0, 0, 1'b0);
    chk("z_done_pulse", frame_done, 1);
    chk("z_busy_end", busy, 0);
    idle(1);
    chk("z_done_single", frame_done, 0);
    chk("z_ndone", ndone - d0, 1);
    chk("z_nout", outs.size(), 24);
    ones = 0;
    foreach (outs[i]) ones += int'(outs[i]);
    chk("z_ones", ones, 0);
    chk("z_ferr", frame_err, 0);
    chk("z_syn", syn_out, 0);
    chk("z_ecnt", err_cnt, 0);

    // codeword equal to g(x)
    outs.delete();
    cw = {23'd0, GP};
    send_frame(cw, 2, 1'b0);
    idle(1);
    chk("g_ferr", frame_err, 0);
    chk("g_syn", syn_out, 0);
    chk("g_msg", pack24(0), 24'h1);

    // single-bit errors in the parity tail
    send_frame(63'h1, 0, 1'b0);
    chk("e1_ferr", frame_err, 1);
    chk("e1_syn", syn_out, 39'h1);
    chk("e1_ecnt", err_cnt, 1);
    send_frame(63'h2, 0, 1'b0);
    chk("e2_syn", syn_out, 39'h2);
    chk("e2_ecnt", err_cnt, 2);
    idle(1);

    // loopback through the reference encoder
    outs.delete(); ferrs.delete(); d0 = ndone;
    for (int f = 0; f < 6; f++) msgs[f] = 24'($urandom);
    msgs[0] = 24'hFFFFFF;
    msgs[1] = 24'h800001;
    for (int f = 0; f < 6; f++) send_frame(encode(msgs[f]), (f % 2) * 3, 1'b0);
    idle(2);
    chk("lb_ndone", ndone - d0, 6);
    bad = 0;
    foreach (ferrs[i]) bad += int'(ferrs[i]);
    chk("lb_ferr", bad, 0);
    chk("lb_nout", outs.size(), 144);
    bad = 0;
    if (outs.size() == 144)
      for (int f = 0; f < 6; f++) if (pack24(f * 24) != msgs[f]) bad++;
    chk("lb_msgs", bad, 0);
    chk("lb_ecnt", err_cnt, 2);

    // sof aborts a partial frame at cnt=30
    d0 = ndone;
    for (int i = 0; i < 30; i++) send_bit(1'b1, 1'b0);
    chk("sof_busy", busy, 1);
    send_frame(63'h0, 0, 1'b1);
    idle(1);
    chk("sof_ndone", ndone - d0, 1);
    chk("sof_ferr", frame_err, 0);
    chk("sof_syn", syn_out, 0);

    // asynchronous reset mid-frame at cnt=40
    send_frame(63'h1, 0, 1'b0);
    chk("pre_ecnt", err_cnt, 3);
    for (int i = 0; i < 40; i++) send_bit(1'b1, 1'b0);
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out", {data_out, data_out_valid, frame_done, frame_err, busy}, 0);
    chk("ar_syn", syn_out, 0);
    chk("ar_ecnt", err_cnt, 0);
    chk("ar_ecnt4", err_cnt4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    d0 = ndone;
    send_frame(63'h0, 0, 1'b0);
    idle(1);
    chk("post_ndone", ndone - d0, 1);
    chk("post_ferr", frame_err, 0);

    // saturation of the narrow error counter
    for (int f = 0; f < 18; f++) send_frame(63'h1, 0, 1'b0);
    idle(2);
    chk("sat_ecnt4", err_cnt4, 4'hF);
    chk("sat_ecnt", err_cnt, 18);
    chk("sat_ferr", frame_err, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
